// File: rtl/bitwise16_bist.sv
// BIST sequencer for a 16-bit combinational bitwise unit: applies four corner
// vectors then N_RAND LFSR-generated vectors, checking each result against the latched op.
module bitwise16_bist #(
  parameter int          N_RAND = 32,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  output logic [15:0] dut_a,
  output logic [15:0] dut_b,
  input  logic [15:0] dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [7:0]  first_fail_idx,
  output logic [15:0] first_fail_got
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  LAST_IDX = 8'(N_RAND + 3);

  logic [1:0]  state;
  logic [7:0]  idx;
  logic [15:0] lfsr;
  logic [1:0]  op_q;

  logic        start_run;
  logic        check_cycle;
  logic        last_vec;
  logic        mismatch;
  logic        first_miss;
  logic [15:0] expected;
  logic [15:0] lfsr_adv;
  logic [7:0]  idx_nxt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] vec_a(input logic [7:0] i, input logic [15:0] l);
    case (i)
      8'd0:    return 16'h0000;
      8'd1:    return 16'hFFFF;
      8'd2:    return 16'hA5A5;
      8'd3:    return 16'hFFFF;
      default: return l;
    endcase
  endfunction

  function automatic logic [15:0] vec_b(input logic [7:0] i, input logic [15:0] l);
    case (i)
      8'd0:    return 16'h0000;
      8'd1:    return 16'h0000;
      8'd2:    return 16'h5A5A;
      8'd3:    return 16'hFFFF;
      default: return ~{l[7:0], l[15:8]};
    endcase
  endfunction

  always_comb begin
    expected = 16'h0000;
    case (op_q)
      2'b00:   expected = dut_a | dut_b;
      2'b01:   expected = dut_a & dut_b;
      2'b10:   expected = dut_a ^ dut_b;
      default: expected = ~(dut_a & dut_b);
    endcase
  end

  assign start_run   = start && ((state == S_IDLE) || (state == S_DONE));
  assign check_cycle = (state == S_CHECK);
  assign last_vec    = (idx == LAST_IDX);
  assign mismatch    = (dut_out != expected);
  assign first_miss  = (first_fail_idx == 8'hFF);
  assign idx_nxt     = idx + 8'd1;
  // The LFSR only moves once a random vector has been consumed, so the
  // first random vector (idx 4) still sees the seed.
  assign lfsr_adv    = (idx >= 8'd4) ? lfsr_step(lfsr) : lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= 8'd0;
      op_q  <= 2'b00;
      lfsr  <= SEED_EFF;
    end else if (start_run) begin
      state <= S_APPLY;
      idx   <= 8'd0;
      op_q  <= op;
      lfsr  <= SEED_EFF;
    end else begin
      case (state)
        S_APPLY: state <= S_CHECK;
        S_CHECK: begin
          lfsr <= lfsr_adv;
          if (last_vec) begin
            state <= S_DONE;
          end else begin
            state <= S_APPLY;
            idx   <= idx_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dut_a <= 16'h0000;
      dut_b <= 16'h0000;
    end else if (start_run) begin
      dut_a <= vec_a(8'd0, SEED_EFF);
      dut_b <= vec_b(8'd0, SEED_EFF);
    end else if (check_cycle) begin
      if (last_vec) begin
        dut_a <= 16'h0000;
        dut_b <= 16'h0000;
      end else begin
        dut_a <= vec_a(idx_nxt, lfsr_adv);
        dut_b <= vec_b(idx_nxt, lfsr_adv);
      end
    end
  end

  // first_fail_idx doubles as the "no failure yet" flag since 8'hFF is never a legal index.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_count     <= 8'd0;
      first_fail_idx <= 8'hFF;
      first_fail_got <= 16'h0000;
    end else if (start_run) begin
      fail_count     <= 8'd0;
      first_fail_idx <= 8'hFF;
      first_fail_got <= 16'h0000;
    end else if (check_cycle && mismatch) begin
      if (fail_count != 8'hFF) begin
        fail_count <= fail_count + 8'd1;
      end
      if (first_miss) begin
        first_fail_idx <= idx;
        first_fail_got <= dut_out;
      end
    end
  end

  assign busy = (state == S_APPLY) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (fail_count == 8'd0);

endmodule

// File: tb/tb_bitwise16_bist.sv
// Testbench for bitwise16_bist: two instances (short run and maximum-length run) driving
// a behavioural combinational unit, checked against a queue-based reference model.
module tb_bitwise16_bist;

  localparam int          NR_S   = 4;
  localparam int          NR_B   = 251;
  localparam logic [15:0] SEED_S = 16'hACE1;
  localparam logic [15:0] SEED_B = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset   = 1'b1;
  logic       start_s = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] op      = 2'b00;
  logic [1:0] mop     = 2'b00;
  int         mode    = 0;

  logic [15:0] a_s, b_s, out_s, ffg_s;
  logic [7:0]  fc_s, ffi_s;
  logic        busy_s, done_s, pass_s;
  logic [15:0] a_b, b_b, out_b, ffg_b;
  logic [7:0]  fc_b, ffi_b;
  logic        busy_b, done_b, pass_b;

  int checks = 0;
  int passed = 0;

  logic [15:0] ref_a[$], ref_b[$];
  logic [15:0] obs_a[$], obs_b[$];

  bitwise16_bist #(.N_RAND(NR_S), .SEED(SEED_S)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .op(op),
    .dut_a(a_s), .dut_b(b_s), .dut_out(out_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_count(fc_s), .first_fail_idx(ffi_s), .first_fail_got(ffg_s)
  );

  bitwise16_bist #(.N_RAND(NR_B), .SEED(SEED_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op(op),
    .dut_a(a_b), .dut_b(b_b), .dut_out(out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fc_b), .first_fail_idx(ffi_b), .first_fail_got(ffg_b)
  );

  function automatic logic [15:0] op_result(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    case (o)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Unit under test models: 0 correct, 1 bit0 stuck low, 2 inverted, 3 data-dependent bit8 flip
  function automatic logic [15:0] model_out(input int md, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = op_result(o, a, b);
    case (md)
      1:       return r & 16'hFFFE;
      2:       return ~r;
      3:       return (a[1:0] == 2'b11) ? (r ^ 16'h0100) : r;
      default: return r;
    endcase
  endfunction

  always_comb out_s = model_out(mode, mop, a_s, b_s);
  always_comb out_b = model_out(mode, mop, a_b, b_b);

  task automatic build_ref(input int nrand, input logic [15:0] seed);
    int l, fb;
    logic [15:0] ca [4];
    logic [15:0] cb [4];
    ca = '{16'h0000, 16'hFFFF, 16'hA5A5, 16'hFFFF};
    cb = '{16'h0000, 16'h0000, 16'h5A5A, 16'hFFFF};
    ref_a.delete();
    ref_b.delete();
    for (int i = 0; i < 4; i++) begin
      ref_a.push_back(ca[i]);
      ref_b.push_back(cb[i]);
    end
    l = (seed == 16'h0000) ? 1 : int'(seed);
    for (int r = 0; r < nrand; r++) begin
      ref_a.push_back(16'(l));
      ref_b.push_back(16'(~(((l % 256) * 256) + (l / 256))));
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      l  = ((l * 2) + fb) % 65536;
    end
  endtask

  task automatic ref_results(input int md, input logic [1:0] mo, input logic [1:0] o,
                             output int fc, output int ffi, output logic [15:0] ffg);
    logic [15:0] got;
    fc  = 0;
    ffi = 255;
    ffg = 16'h0000;
    for (int i = 0; i < ref_a.size(); i++) begin
      got = model_out(md, mo, ref_a[i], ref_b[i]);
      if (got != op_result(o, ref_a[i], ref_b[i])) begin
        if (fc < 255) fc++;
        if (ffi == 255) begin
          ffi = i;
          ffg = got;
        end
      end
    end
  endtask

  // Pulses start on the chosen instance and records dut_a/dut_b every busy cycle.
  task automatic do_run(input bit big, input int poke, output int cycles, output bit timeout, output int bad_pass);
    @(negedge clk);
    if (big) start_b = 1'b1;
    else     start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_b = 1'b0;
    obs_a.delete();
    obs_b.delete();
    cycles   = 0;
    timeout  = 1'b1;
    bad_pass = 0;
    for (int k = 0; k < 1200; k++) begin
      if (big ? done_b : done_s) begin
        timeout = 1'b0;
        break;
      end
      if (big ? pass_b : pass_s) bad_pass++;
      if (big ? busy_b : busy_s) begin
        cycles++;
        obs_a.push_back(big ? a_b : a_s);
        obs_b.push_back(big ? b_b : b_s);
      end
      if (!big && poke > 0 && cycles == poke) begin
        start_s = 1'b1;
        op      = 2'b01;
      end else begin
        start_s = 1'b0;
      end
      @(negedge clk);
    end
    start_s = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if ({a_s, b_s} !== 32'h0) $display("[TB] FAIL reset_operands got %h/%h want 0000/0000", a_s, b_s); else passed++;
    checks++; if ({busy_s, done_s, pass_s} !== 3'b000) $display("[TB] FAIL reset_flags got %b want 000", {busy_s, done_s, pass_s}); else passed++;
    checks++; if (fc_s !== 8'd0) $display("[TB] FAIL reset_fail_count got %0d want 0", fc_s); else passed++;
    checks++; if (ffi_s !== 8'hFF) $display("[TB] FAIL reset_first_idx got %h want ff", ffi_s); else passed++;
    checks++; if (ffg_s !== 16'h0) $display("[TB] FAIL reset_first_got got %h want 0000", ffg_s); else passed++;
    checks++; if ({busy_b, done_b, ffi_b} !== {2'b00, 8'hFF}) $display("[TB] FAIL reset_big got busy=%b done=%b idx=%h want 0 0 ff", busy_b, done_b, ffi_b); else passed++;
  endtask

  task automatic test_or_correct();
    int cyc, badp;
    bit to;
    op = 2'b00; mop = 2'b00; mode = 0;
    build_ref(NR_S, SEED_S);
    do_run(1'b0, 0, cyc, to, badp);
    checks++; if (to || cyc != 16) $display("[TB] FAIL or_run_length got %0d timeout=%0b want 16", cyc, to); else passed++;
    checks++; if ({done_s, pass_s} !== 2'b11) $display("[TB] FAIL or_done_pass got %b want 11", {done_s, pass_s}); else passed++;
    checks++; if ({fc_s, ffi_s, ffg_s} !== {8'd0, 8'hFF, 16'h0}) $display("[TB] FAIL or_results got %0d/%h/%h want 0/ff/0000", fc_s, ffi_s, ffg_s); else passed++;
    checks++; if (badp != 0) $display("[TB] FAIL or_pass_while_running got %0d want 0", badp); else passed++;
    for (int i = 0; i < ref_a.size(); i++) begin
      checks++;
      if (obs_a.size() < 2 * i + 2 || {obs_a[2*i], obs_b[2*i], obs_a[2*i+1], obs_b[2*i+1]} !== {ref_a[i], ref_b[i], ref_a[i], ref_b[i]})
        $display("[TB] FAIL or_vector%0d got %h/%h want %h/%h", i, obs_a[2*i], obs_b[2*i], ref_a[i], ref_b[i]);
      else passed++;
    end
    repeat (3) @(negedge clk);
    checks++; if ({done_s, pass_s, a_s, b_s} !== {2'b11, 32'h0}) $display("[TB] FAIL or_done_hold got done=%b pass=%b a=%h b=%h want 1 1 0 0", done_s, pass_s, a_s, b_s); else passed++;
  endtask

  task automatic test_stuck_bit();
    int cyc, badp, efc, effi;
    bit to;
    logic [15:0] effg;
    op = 2'b00; mop = 2'b00; mode = 1;
    build_ref(NR_S, SEED_S);
    ref_results(1, 2'b00, 2'b00, efc, effi, effg);
    do_run(1'b0, 0, cyc, to, badp);
    checks++; if (to || {done_s, pass_s} !== 2'b10) $display("[TB] FAIL stuck_done_pass got %b timeout=%0b want 10", {done_s, pass_s}, to); else passed++;
    checks++; if ({ffi_s, ffg_s} !== {8'd1, 16'hFFFE}) $display("[TB] FAIL stuck_first got %h/%h want 01/fffe", ffi_s, ffg_s); else passed++;
    checks++; if (fc_s < 8'd3 || fc_s !== 8'(efc)) $display("[TB] FAIL stuck_fail_count got %0d want %0d", fc_s, efc); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, badp;
    bit to;
    mode = 0;
    do_run(1'b0, 0, cyc, to, badp);
    checks++; if (to || cyc != 16) $display("[TB] FAIL b2b_run_length got %0d timeout=%0b want 16", cyc, to); else passed++;
    checks++; if ({pass_s, fc_s, ffi_s, ffg_s} !== {1'b1, 8'd0, 8'hFF, 16'h0}) $display("[TB] FAIL b2b_results got pass=%b %0d/%h/%h want 1 0/ff/0000", pass_s, fc_s, ffi_s, ffg_s); else passed++;
  endtask

  task automatic test_midrun_start();
    int cyc, badp;
    bit to;
    op = 2'b00; mop = 2'b00; mode = 0;
    do_run(1'b0, 5, cyc, to, badp);
    checks++; if (to || cyc != 16) $display("[TB] FAIL midrun_run_length got %0d timeout=%0b want 16", cyc, to); else passed++;
    checks++; if ({done_s, pass_s, fc_s} !== {2'b11, 8'd0}) $display("[TB] FAIL midrun_pass got done=%b pass=%b fails=%0d want 1 1 0", done_s, pass_s, fc_s); else passed++;
  endtask

  task automatic test_reset_abort();
    int cyc, badp, cnt;
    bit to;
    op = 2'b00; mop = 2'b00; mode = 1;
    build_ref(NR_S, SEED_S);
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_s) cnt++;
      if (cnt == 5) break;
      @(negedge clk);
    end
    checks++; if ({a_s, b_s, fc_s, pass_s} !== {16'hA5A5, 16'h5A5A, 8'd1, 1'b0}) $display("[TB] FAIL abort_midrun got a=%h b=%h fails=%0d pass=%b want a5a5 5a5a 1 0", a_s, b_s, fc_s, pass_s); else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy_s, done_s, a_s, b_s} !== {2'b00, 32'h0}) $display("[TB] FAIL abort_idle got busy=%b done=%b a=%h b=%h want 0 0 0 0", busy_s, done_s, a_s, b_s); else passed++;
    checks++; if ({fc_s, ffi_s, ffg_s} !== {8'd0, 8'hFF, 16'h0}) $display("[TB] FAIL abort_cleared got %0d/%h/%h want 0/ff/0000", fc_s, ffi_s, ffg_s); else passed++;
    mode = 0;
    do_run(1'b0, 0, cyc, to, badp);
    checks++; if (to || cyc != 16 || pass_s !== 1'b1) $display("[TB] FAIL abort_rerun got cycles=%0d pass=%b timeout=%0b want 16 1 0", cyc, pass_s, to); else passed++;
    checks++; if (obs_a.size() < 1 || {obs_a[0], obs_b[0]} !== {ref_a[0], ref_b[0]}) $display("[TB] FAIL abort_rerun_idx0 got %h/%h want %h/%h", obs_a[0], obs_b[0], ref_a[0], ref_b[0]); else passed++;
  endtask

  task automatic test_random_ops();
    int cyc, badp, efc, effi;
    bit to;
    logic [15:0] effg;
    build_ref(NR_S, SEED_S);
    for (int it = 0; it < 6; it++) begin
      op   = 2'($urandom_range(0, 3));
      mop  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : op;
      mode = ($urandom_range(0, 1) == 1) ? 3 : 0;
      ref_results(mode, mop, op, efc, effi, effg);
      do_run(1'b0, 0, cyc, to, badp);
      checks++;
      if (to || {fc_s, ffi_s, ffg_s, pass_s} !== {8'(efc), 8'(effi), effg, (efc == 0)})
        $display("[TB] FAIL random%0d op=%0d model=%0d/%0d got %0d/%h/%h pass=%b want %0d/%h/%h", it, op, mode, mop, fc_s, ffi_s, ffg_s, pass_s, efc, effi, effg);
      else passed++;
      for (int i = 0; i < ref_a.size(); i++) begin
        checks++;
        if (obs_a.size() < 2 * i + 2 || {obs_a[2*i], obs_b[2*i], obs_a[2*i+1], obs_b[2*i+1]} !== {ref_a[i], ref_b[i], ref_a[i], ref_b[i]})
          $display("[TB] FAIL random%0d_vector%0d got %h/%h want %h/%h", it, i, obs_a[2*i], obs_b[2*i], ref_a[i], ref_b[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_saturate();
    int cyc, badp, efc, effi, bad_vec;
    bit to;
    logic [15:0] effg;
    op = 2'b00; mop = 2'b00; mode = 2;
    build_ref(NR_B, SEED_B);
    ref_results(2, 2'b00, 2'b00, efc, effi, effg);
    do_run(1'b1, 0, cyc, to, badp);
    checks++; if (to || cyc != 2 * (4 + NR_B)) $display("[TB] FAIL sat_run_length got %0d timeout=%0b want %0d", cyc, to, 2 * (4 + NR_B)); else passed++;
    checks++; if ({done_b, pass_b, fc_b} !== {2'b10, 8'd255} || efc != 255) $display("[TB] FAIL sat_fail_count got done=%b pass=%b fails=%0d want 1 0 255", done_b, pass_b, fc_b); else passed++;
    checks++; if ({ffi_b, ffg_b} !== {8'd0, 16'hFFFF} || 8'(effi) !== ffi_b) $display("[TB] FAIL sat_first got %h/%h want 00/ffff", ffi_b, ffg_b); else passed++;
    bad_vec = 0;
    for (int i = 0; i < ref_a.size(); i++) begin
      if (obs_a.size() < 2 * i + 2 || {obs_a[2*i], obs_b[2*i], obs_a[2*i+1], obs_b[2*i+1]} !== {ref_a[i], ref_b[i], ref_a[i], ref_b[i]})
        bad_vec++;
    end
    checks++; if (bad_vec != 0) $display("[TB] FAIL sat_vectors got %0d bad vectors want 0", bad_vec); else passed++;
  endtask

  initial begin
    $display("[TB] bitwise16_bist bench starting");
    test_reset();
    test_or_correct();
    test_stuck_bit();
    test_back_to_back();
    test_midrun_start();
    test_reset_abort();
    test_random_ops();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bitwise16_bist.md
BITWISE16_BIST -- requirements
Module: bitwise16_bist

Interface
REQ-001 The block SHALL have parameter N_RAND, default 32, giving the number of pseudo-random vectors applied after the corner vectors (legal range 1..251).
REQ-002 The block SHALL have parameter SEED, default 16'hACE1, giving the LFSR start value; a SEED of 0 SHALL be replaced by 16'h0001.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have these ports:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  start  in  1  run request, sampled only in IDLE or DONE
  op  in  2  operation under test: 00 OR, 01 AND, 10 XOR, 11 NAND
  dut_a  out  16  operand a driven to the combinational DUT
  dut_b  out  16  operand b driven to the combinational DUT
  dut_out  in  16  DUT result
  busy  out  1  high in APPLY and CHECK
  done  out  1  high in DONE
  pass  out  1  high in DONE when fail_count == 0
  fail_count  out  8  mismatching vectors, saturating at 255
  first_fail_idx  out  8  index of the first mismatch, 8'hFF if none
  first_fail_got  out  16  dut_out captured at the first mismatch, 0 if none

Function
REQ-005 The FSM SHALL have the states IDLE, APPLY, CHECK and DONE.
REQ-006 IDLE or DONE with start=1 SHALL go to APPLY at the next edge, latch op, clear the result outputs, set the vector index to 0 and load the LFSR with SEED.
REQ-007 APPLY SHALL go to CHECK unconditionally after one cycle, giving one settle cycle.
REQ-008 CHECK SHALL compare dut_out with expected at the edge leaving CHECK, then go to APPLY with index+1, or to DONE if index == 3+N_RAND.
REQ-009 DONE SHALL hold all result outputs until start or reset.
REQ-010 Each vector SHALL take 2 cycles, so T = 4+N_RAND vectors take 2T cycles from the start-sampling edge to done=1.
REQ-011 The corner vectors SHALL be (a,b): idx0 (0000,0000), idx1 (FFFF,0000), idx2 (A5A5,5A5A), idx3 (FFFF,FFFF).
REQ-012 For idx>=4, a SHALL equal the LFSR state and b SHALL equal ~{lfsr[7:0],lfsr[15:8]}.
REQ-013 The LFSR SHALL advance once per random vector, on the edge leaving CHECK.
REQ-014 The LFSR SHALL be Fibonacci x^16+x^14+x^13+x^11+1: shift left, bit0 = l[15]^l[13]^l[12]^l[10].
REQ-015 dut_a and dut_b SHALL be registered and held stable across APPLY and CHECK of a vector.
REQ-016 dut_a and dut_b SHALL be 0 in IDLE and DONE.
REQ-017 expected SHALL be computed from the latched op: a|b, a&b, a^b, or ~(a&b).
REQ-018 On a mismatch, fail_count SHALL increment unless it is already 255.
REQ-019 On the first mismatch of a run only, first_fail_idx SHALL capture the index and first_fail_got SHALL capture dut_out.
REQ-020 start while busy=1 SHALL be ignored, and changes on op during a run SHALL have no effect.
REQ-021 pass SHALL be 0 whenever done=0.

Reset
REQ-022 reset SHALL take priority over all other inputs and, at the next edge, force state IDLE, dut_a=dut_b=0, busy=done=pass=0, fail_count=0, first_fail_idx=8'hFF, first_fail_got=0, and LFSR=SEED.
REQ-023 reset asserted during a run SHALL abort it with no residual state, and a later start SHALL run from idx0.

Verification
REQ-024 Reset then idle 5 cycles -> all outputs at their reset values, first_fail_idx=FF.
REQ-025 N_RAND=4, correct OR model, op=00, 1-cycle start -> busy for 16 cycles, then done=1, pass=1, fail_count=0; vectors idx0..3 seen on dut_a/dut_b exactly as listed.
REQ-026 DUT=OR with bit0 stuck at 0, op=00 -> pass=0, first_fail_idx=1, first_fail_got=FFFE, fail_count>=3.
REQ-027 Pulse start and toggle op to 01 during cycle 5 of a run with a correct OR model -> no restart, run length unchanged, pass=1.
REQ-028 reset asserted while idx=2 -> IDLE next cycle with counters cleared; a new start completes with pass=1 against a correct model.
REQ-029 N_RAND=251, DUT output always inverted -> fail_count=255 (saturated), first_fail_idx=0, first_fail_got=FFFF, done=1, pass=0.
